cfg_serializer: RTL and testbench



---
 rtl/cfg_pkg.sv | 39 +++
 rtl/cfg_phase_timer.sv | 35 +++
 rtl/cfg_serializer.sv | 156 +++++++++++++++
 tb/tb_cfg_serializer.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_pkg.sv
// Shared types and constants for the configuration-word serializer.
// Bit positions describe the 18-bit downstream configuration register layout.
package cfg_pkg;

  localparam int CFG_WIDTH = 18;

  localparam int DT_LSB          = 0;
  localparam int DT_MSB          = 4;
  localparam int SEL_GEN1_LSB    = 5;
  localparam int SEL_GEN1_MSB    = 6;
  localparam int SEL_GEN2_LSB    = 7;
  localparam int SEL_GEN2_MSB    = 8;
  localparam int OUT_SEL_EXT_LSB = 9;
  localparam int OUT_SEL_EXT_MSB = 12;
  localparam int INPUT_SEL       = 13;
  localparam int CLK_SEL         = 14;
  localparam int PS_SEL          = 15;
  localparam int PS3_SEL         = 16;
  localparam int ENABLE_OUT      = 17;

  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_IDLE     = 3'd1,
    ST_CLEAR    = 3'd2,
    ST_SHIFT_LO = 3'd3,
    ST_SHIFT_HI = 3'd4,
    ST_DONE     = 3'd5
  } cfg_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One counter serves both the CLEAR and the half-period timing.
  function automatic int phase_cnt_width(input int clk_div, input int rst_cycles);
    return $clog2(max_int(clk_div, rst_cycles) + 1);
  endfunction

endpackage

// File: rtl/cfg_phase_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
// Loading N-1 on a phase change makes the phase last exactly N cycles.
module cfg_phase_timer #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/cfg_serializer.sv
// Serializes a parallel configuration word into the downstream shift register:
// SR_RST re-arm pulse, then WIDTH LSB-first bits on flop-driven SR_CLK/SR_DATA.
module cfg_serializer
  import cfg_pkg::*;
#(
  parameter int WIDTH      = CFG_WIDTH,
  parameter int CLK_DIV    = 4,
  parameter int RST_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] cfg_word,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic             SR_CLK,
  output logic             SR_DATA,
  output logic             SR_RST,
  output logic             busy,
  output logic             done,
  output cfg_state_e       dbg_state
);

  // Handshake: a word transfers on any CLK edge where cfg_valid & cfg_ready are
  // both high; cfg_valid may be held, cfg_word need only be stable at that edge.

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CNT_W = phase_cnt_width(CLK_DIV, RST_CYCLES);

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] PHASE_LOAD = CNT_W'(CLK_DIV - 1);

  cfg_state_e       state_q, state_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic sr_clk_q, sr_clk_d;
  logic sr_data_q, sr_data_d;
  logic sr_rst_q, sr_rst_d;
  logic cfg_ready_q, cfg_ready_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic             timer_load;
  logic [CNT_W-1:0] timer_val;
  logic             timer_expired;

  cfg_phase_timer #(
    .CNT_W (CNT_W)
  ) u_phase_timer (
    .clk      (CLK),
    .rst_n    (RST_N),
    .load     (timer_load),
    .load_val (timer_val),
    .expired  (timer_expired)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_INIT;
      shadow_q    <= '0;
      idx_q       <= '0;
      sr_clk_q    <= 1'b0;
      sr_data_q   <= 1'b0;
      sr_rst_q    <= 1'b1;
      cfg_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      idx_q       <= idx_d;
      sr_clk_q    <= sr_clk_d;
      sr_data_q   <= sr_data_d;
      sr_rst_q    <= sr_rst_d;
      cfg_ready_q <= cfg_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    idx_d    = idx_q;
    case (state_q)
      ST_INIT: begin
        state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (cfg_valid && cfg_ready_q) begin
          shadow_d = cfg_word;
          idx_d    = '0;
          state_d  = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (timer_expired) begin
          state_d = ST_SHIFT_LO;
        end
      end
      ST_SHIFT_LO: begin
        if (timer_expired) begin
          state_d = ST_SHIFT_HI;
        end
      end
      ST_SHIFT_HI: begin
        if (timer_expired) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_SHIFT_LO;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Every state change starts a new phase, so the timer reloads on it.
  always_comb begin
    timer_load = (state_d != state_q);
    timer_val  = (state_d == ST_CLEAR) ? CLEAR_LOAD : PHASE_LOAD;
  end

  // Outputs decode the next state so they change on the same edge as the state.
  always_comb begin
    sr_rst_d    = (state_d == ST_INIT) || (state_d == ST_CLEAR);
    sr_clk_d    = (state_d == ST_SHIFT_HI);
    cfg_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d == ST_CLEAR) || (state_d == ST_SHIFT_LO) ||
                  (state_d == ST_SHIFT_HI) || (state_d == ST_DONE);
    done_d      = (state_d == ST_DONE);
    sr_data_d   = 1'b0;
    if (state_d == ST_SHIFT_LO) begin
      sr_data_d = shadow_q[idx_d];
    end else if (state_d == ST_SHIFT_HI) begin
      sr_data_d = sr_data_q;
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign SR_CLK    = sr_clk_q;
  assign SR_DATA   = sr_data_q;
  assign SR_RST    = sr_rst_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_cfg_serializer.sv
// Scoreboard bench for cfg_serializer: a default instance and a fast
// (CLK_DIV=1, RST_CYCLES=1) instance, each checked against a timing model.
module tb_cfg_serializer;
  import cfg_pkg::*;

  localparam int W     = 18;
  localparam int R_A   = 2;
  localparam int D_A   = 4;
  localparam int R_B   = 1;
  localparam int D_B   = 1;
  localparam int LAT_A = R_A + 2 * D_A * W + 1;
  localparam int LAT_B = R_B + 2 * D_B * W + 1;

  typedef struct packed {
    logic sr_rst;
    logic sr_clk;
    logic sr_data;
    logic ready;
    logic busy;
    logic done;
  } exp_t;

  localparam exp_t RST_EXP  = 6'b100000;
  localparam exp_t IDLE_EXP = 6'b000100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [W-1:0] a_word, b_word;
  logic         a_valid, b_valid;
  logic         a_ready, a_sr_clk, a_sr_data, a_sr_rst, a_busy, a_done;
  logic         b_ready, b_sr_clk, b_sr_data, b_sr_rst, b_busy, b_done;
  cfg_state_e   a_dbg, b_dbg;

  int checks = 0;
  int errors = 0;

  cfg_serializer dut_a (
    .CLK       (clk),
    .RST_N     (rst_n),
    .cfg_word  (a_word),
    .cfg_valid (a_valid),
    .cfg_ready (a_ready),
    .SR_CLK    (a_sr_clk),
    .SR_DATA   (a_sr_data),
    .SR_RST    (a_sr_rst),
    .busy      (a_busy),
    .done      (a_done),
    .dbg_state (a_dbg)
  );

  cfg_serializer #(
    .WIDTH      (W),
    .CLK_DIV    (D_B),
    .RST_CYCLES (R_B)
  ) dut_b (
    .CLK       (clk),
    .RST_N     (rst_n),
    .cfg_word  (b_word),
    .cfg_valid (b_valid),
    .cfg_ready (b_ready),
    .SR_CLK    (b_sr_clk),
    .SR_DATA   (b_sr_data),
    .SR_RST    (b_sr_rst),
    .busy      (b_busy),
    .done      (b_done),
    .dbg_state (b_dbg)
  );

  // ---------------- behavioural downstream registers ----------------
  logic [W-1:0] ds_a, ds_b;
  int           ds_cnt_a, ds_cnt_b;

  always @(posedge a_sr_clk or posedge a_sr_rst) begin
    if (a_sr_rst) begin
      ds_a     <= '0;
      ds_cnt_a <= 0;
    end else begin
      ds_a     <= {a_sr_data, ds_a[W-1:1]};
      ds_cnt_a <= ds_cnt_a + 1;
    end
  end

  always @(posedge b_sr_clk or posedge b_sr_rst) begin
    if (b_sr_rst) begin
      ds_b     <= '0;
      ds_cnt_b <= 0;
    end else begin
      ds_b     <= {b_sr_data, ds_b[W-1:1]};
      ds_cnt_b <= ds_cnt_b + 1;
    end
  end

  // ---------------- reference model ----------------
  // Expected outputs in cycle k (1-based) after the accepting edge.
  function automatic exp_t frame_exp(input int k, input int r, input int d,
                                     input logic [W-1:0] w);
    exp_t e;
    int   j;
    e      = '0;
    e.busy = 1'b1;
    if (k <= r) begin
      e.sr_rst = 1'b1;
    end else if (k <= r + 2 * d * W) begin
      j         = k - r - 1;
      e.sr_clk  = ((j % (2 * d)) >= d);
      e.sr_data = w[j / (2 * d)];
    end else begin
      e.done = 1'b1;
    end
    return e;
  endfunction

  task automatic check_out(input string tag, input int k, input exp_t want, input exp_t got);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s phase=%0d got rst,clk,dat,rdy,bsy,done=%b want=%b at %0t",
               tag, k, got, want, $time);
    end
  endtask

  task automatic check_frame(input string tag, input logic [W-1:0] ds, input int cnt,
                             input logic [W-1:0] want);
    checks++;
    if (ds !== want || cnt != W) begin
      errors++;
      $display("FAIL %s data_out got %h (%0d edges) want %h (%0d edges)",
               tag, ds, cnt, want, W);
    end
  endtask

  // ---------------- scoreboards / monitors ----------------
  int           phase_a = -1, phase_b = -1;
  int           acc_a = 0, acc_b = 0;
  logic [W-1:0] word_a, word_b;
  logic [W-1:0] exp_q_a[$];
  logic [W-1:0] exp_q_b[$];

  always @(negedge clk) begin : mon_a
    exp_t         want;
    int           nxt;
    logic [W-1:0] exp_w;
    want = IDLE_EXP;
    nxt  = 0;
    if (rst_n !== 1'b1) begin
      want = RST_EXP;
      exp_q_a.delete();
      nxt = -1;
      checks++;
      if (a_dbg !== ST_INIT) begin
        errors++;
        $display("FAIL a_reset_state got %0d want %0d", a_dbg, ST_INIT);
      end
    end else if (phase_a < 0) begin
      want = RST_EXP;
    end else if (phase_a == 0) begin
      if (a_valid) begin
        exp_q_a.push_back(a_word);
        word_a = a_word;
        acc_a++;
        nxt = 1;
      end
    end else begin
      want = frame_exp(phase_a, R_A, D_A, word_a);
      nxt  = phase_a + 1;
      if (phase_a == LAT_A) begin
        nxt = 0;
        if (exp_q_a.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL a_scoreboard got empty queue want one entry");
        end else begin
          exp_w = exp_q_a.pop_front();
          check_frame("a_frame", ds_a, ds_cnt_a, exp_w);
        end
      end
    end
    check_out("a_outputs", phase_a, want,
              {a_sr_rst, a_sr_clk, a_sr_data, a_ready, a_busy, a_done});
    phase_a = nxt;
  end

  always @(negedge clk) begin : mon_b
    exp_t         want;
    int           nxt;
    logic [W-1:0] exp_w;
    want = IDLE_EXP;
    nxt  = 0;
    if (rst_n !== 1'b1) begin
      want = RST_EXP;
      exp_q_b.delete();
      nxt = -1;
      checks++;
      if (b_dbg !== ST_INIT) begin
        errors++;
        $display("FAIL b_reset_state got %0d want %0d", b_dbg, ST_INIT);
      end
    end else if (phase_b < 0) begin
      want = RST_EXP;
    end else if (phase_b == 0) begin
      if (b_valid) begin
        exp_q_b.push_back(b_word);
        word_b = b_word;
        acc_b++;
        nxt = 1;
      end
    end else begin
      want = frame_exp(phase_b, R_B, D_B, word_b);
      nxt  = phase_b + 1;
      if (phase_b == LAT_B) begin
        nxt = 0;
        if (exp_q_b.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b_scoreboard got empty queue want one entry");
        end else begin
          exp_w = exp_q_b.pop_front();
          check_frame("b_frame", ds_b, ds_cnt_b, exp_w);
        end
      end
    end
    check_out("b_outputs", phase_b, want,
              {b_sr_rst, b_sr_clk, b_sr_data, b_ready, b_busy, b_done});
    phase_b = nxt;
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic send_a(input logic [W-1:0] w, input bit keep);
    int start;
    bit ok;
    start   = acc_a;
    ok      = 1'b0;
    a_word  = w;
    a_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (acc_a != start) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL a_accept_timeout word=%h got no handshake want one", w);
    end
    if (!keep) a_valid = 1'b0;
  endtask

  task automatic send_b(input logic [W-1:0] w, input bit keep);
    int start;
    bit ok;
    start   = acc_b;
    ok      = 1'b0;
    b_word  = w;
    b_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (acc_b != start) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL b_accept_timeout word=%h got no handshake want one", w);
    end
    if (!keep) b_valid = 1'b0;
  endtask

  task automatic wait_phase_a(input int target);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (phase_a == target || (target == 0 && phase_a == 0)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL a_wait_timeout phase got %0d want %0d", phase_a, target);
    end
  endtask

  task automatic wait_idle_b();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (phase_b == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL b_wait_timeout phase got %0d want 0", phase_b);
    end
  endtask

  task automatic noise_a(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      a_word  = W'($urandom);
      a_valid = 1'($urandom_range(0, 1));
    end
    a_valid = 1'b0;
  endtask

  task automatic noise_b(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      b_word  = W'($urandom);
      b_valid = 1'($urandom_range(0, 1));
    end
    b_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    a_valid = 1'b0;
    a_word  = '0;
    b_valid = 1'b1;
    b_word  = 18'h2A5C3;
    repeat (3) @(posedge clk);
    #4 rst_n = 1'b1;

    // fast instance: valid held through reset is taken on the first IDLE edge
    send_b(18'h2A5C3, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    send_a(18'h2A5C3, 1'b0);
    wait_phase_a(0);

    send_a(18'h00001, 1'b0);
    a_word = 18'h3FFFF;
    wait_phase_a(0);

    send_a(18'h12345, 1'b1);
    send_a(18'h0F0F0, 1'b0);
    wait_phase_a(0);

    // reset during bit 9, then a fresh frame
    send_a(W'($urandom), 1'b0);
    wait_phase_a(R_A + 9 * 2 * D_A + 1 + $urandom_range(0, 2 * D_A - 1));
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_a(18'h3FFFF, 1'b0);
    wait_phase_a(0);

    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 5)) @(posedge clk);
      #1;
      send_a(W'($urandom), 1'b0);
      noise_a(100);
      wait_phase_a(0);
    end

    wait_idle_b();
    send_b(18'h00001, 1'b0);
    b_word = 18'h3FFFF;
    wait_idle_b();
    send_b(18'h12345, 1'b1);
    send_b(18'h0F0F0, 1'b0);
    wait_idle_b();
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 5)) @(posedge clk);
      #1;
      send_b(W'($urandom), 1'b0);
      noise_b(20);
      wait_idle_b();
    end

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog got no end of test want finish before %0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
